aabb_closest_hit: RTL and testbench
===================================

Name: aabb_closest_hit

Overview:
- Sits directly downstream of the AABB primitive test unit.
- Consumes its per-(ray, box) result stream and keeps, per ray tag, a running nearest hit across BOX_COUNT boxes.
- When all boxes for a tag have reported, emits one closest-hit record into an output FIFO toward the shading/writeback stage.
- The upstream stage has no backpressure, so every input beat must be accepted.

Parameters:
- WIDTH, `WIDTH, fixed-point word width of tmin.
- Q_BITS, `Q_BITS, fractional bits. Informational only; comparisons are signed integer.
- TAG_SIZE, `TAG_SIZE, ray tag width; the table has 2**TAG_SIZE entries.
- BOX_COUNT, 8, results expected per tag before emission (>=1).
- MAX, `MAX_16, "no hit" tmin value.
- OUT_DEPTH, 16, output FIFO depth (power of two).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted = 0)
- in_valid  in  1  one beat of AABB result present this cycle
- in_result  in  AABB_result  box, ray_hit, tag, tmin from the AABB stage
- clear  in  1  synchronous flush of all table entries
- out_valid  out  1  output FIFO non-empty
- out_ready  in  1  consumer accepts the head record
- out_hit  out  ClosestHit  tag, hit, tmin, box of the nearest hit
- overflow  out  1  sticky: a completed record was dropped because the FIFO was full
- busy  out  1  at least one table entry has count != 0

Behaviour:
- Reset (reset == 0, asynchronous):
  - All entries cleared: count=0, best_hit=0, best_tmin=MAX, best_box='0.
  - FIFO emptied; out_valid=0, out_hit='0, overflow=0, busy=0.
  - Mid-operation reset discards partial accumulations and queued records.
- Table per tag:
  - count, width $clog2(BOX_COUNT+1).
  - best_hit, best_tmin (signed WIDTH), best_box (AABB).
  - Held in flops; combinational read, written on clk.
- Accept (in_valid=1), single-cycle read-modify-write on entry e = table[in_result.tag]:
  - take = in_result.ray_hit && (!e.best_hit || in_result.tmin < e.best_tmin). Compare is signed; ties keep the earlier box (strict <).
  - nb = take ? {1, in_result.tmin, in_result.box} : {e.best_hit, e.best_tmin, e.best_box}.
  - If e.count == BOX_COUNT-1: push {tag, nb} to the FIFO and reset the entry to cleared values. If the FIFO is full, the push is dropped and overflow is set to 1.
  - Otherwise: entry = {e.count+1, nb}.
  - Consecutive beats with the same tag are legal every cycle. No forwarding is needed, because each write lands before the next read.
- Latency: the record written at edge N is visible on out_valid/out_hit after edge N (FWFT); minimum 1 cycle from the last contributing beat.
- Emitted record with no hits: hit=0, tmin=MAX, box='0.
- Output handshake:
  - Pop on out_valid && out_ready.
  - out_hit holds stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle on a full FIFO succeeds: the pop frees the slot, so no overflow.
- clear=1:
  - All entries are cleared at the next edge; any in_valid beat that cycle is ignored.
  - FIFO contents are kept.
  - overflow is unchanged; it clears only on reset.
- busy = OR of (count != 0) over all entries, registered.
- An in_valid beat for a tag whose count is already 0 after emission starts a new accumulation. Tag reuse is legal.

Decomposition:
- Shared package (Types.sv):
  - ClosestHit struct {tag [TAG_SIZE-1:0], hit, tmin signed [WIDTH-1:0], box AABB}.
  - HitEntry struct for the table row.
  - MAX_16 constant is reused.
- Sub-module closest_hit_fifo:
  - Parameterised FWFT FIFO, WIDTH=$bits(ClosestHit), DEPTH=OUT_DEPTH.
  - Ports: push, pop, full, empty, data_in/data_out.
  - Asynchronous active-low reset.
- Top level contains the table, update logic, overflow/busy flops.

Test Plan:
- BOX_COUNT=4, tag 3, results hit/tmin = (1, 0x0005_0000), (0, MAX), (1, 0x0002_0000), (1, 0x0002_0000 box B2) -> one record: tag 3, hit=1, tmin 0x0002_0000, box = the first 2.0 box (tie kept), out_valid 1 cycle after the 4th beat.
- Tag 5, four misses -> record hit=0, tmin=MAX, box='0; entry back to count 0; busy falls to 0.
- Interleaved tags 1,2,1,2,... every cycle, 8 beats -> two records, tag 1 first then tag 2, each carrying its own minimum. No cross-tag corruption.
- out_ready=0, complete OUT_DEPTH+1 tags -> first OUT_DEPTH queued in order, last dropped, overflow=1 and stays 1; drain, then verify FIFO order.
- Tag 7 with 2 of 4 beats, assert reset=0 for one cycle, then 4 beats with tmin 0x0003_0000 hit -> exactly one record, tmin 0x0003_0000, no stale data. Repeat using clear instead of reset: same result.
- Full FIFO with out_ready=1 and a completion in the same cycle -> push accepted, overflow stays 0, occupancy unchanged.

Source files
------------

// File: rtl/aabb_closest_hit_pkg.sv
// rtl/aabb_closest_hit_pkg.sv - shared types and constants for the AABB closest-hit reducer
package aabb_closest_hit_pkg;

    localparam int WIDTH    = 32;
    localparam int Q_BITS   = 16;
    localparam int TAG_SIZE = 3;

    localparam logic signed [WIDTH-1:0] MAX_16 = 32'sh7fff_ffff;

    typedef struct packed {
        logic [7:0] x_min;
        logic [7:0] y_min;
        logic [7:0] z_min;
        logic [7:0] x_max;
        logic [7:0] y_max;
        logic [7:0] z_max;
    } AABB;

    typedef struct packed {
        AABB                       box;
        logic                      ray_hit;
        logic [TAG_SIZE-1:0]       tag;
        logic signed [WIDTH-1:0]   tmin;
    } AABB_result;

    typedef struct packed {
        logic [TAG_SIZE-1:0]       tag;
        logic                      hit;
        logic signed [WIDTH-1:0]   tmin;
        AABB                       box;
    } ClosestHit;

    typedef struct packed {
        logic                      hit;
        logic signed [WIDTH-1:0]   tmin;
        AABB                       box;
    } HitEntry;

    localparam HitEntry ENTRY_CLEAR = '{hit: 1'b0, tmin: MAX_16, box: '0};

    // Whole number to Q(WIDTH-Q_BITS).Q_BITS fixed point.
    function automatic logic signed [WIDTH-1:0] fx(input int whole);
        return WIDTH'(whole) <<< Q_BITS;
    endfunction

endpackage

// File: rtl/closest_hit_fifo.sv
// rtl/closest_hit_fifo.sv - first-word-fall-through FIFO for completed closest-hit records
module closest_hit_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/aabb_closest_hit.sv
// rtl/aabb_closest_hit.sv - per-tag nearest-hit reduction over BOX_COUNT AABB results
module aabb_closest_hit
    import aabb_closest_hit_pkg::*;
#(
    parameter int BOX_COUNT = 8,
    parameter int OUT_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  AABB_result in_result,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output ClosestHit  out_hit,
    output logic       overflow,
    output logic       busy
);
    localparam int              CNT_W   = $clog2(BOX_COUNT + 1);
    localparam int              ENTRIES = 2 ** TAG_SIZE;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(BOX_COUNT - 1);

    HitEntry          best_q  [ENTRIES];
    HitEntry          best_d  [ENTRIES];
    logic [CNT_W-1:0] count_q [ENTRIES];
    logic [CNT_W-1:0] count_d [ENTRIES];

    HitEntry          cur;
    HitEntry          nb;
    logic             take;
    logic             done;
    logic             busy_d;
    logic             fifo_full;
    logic             fifo_empty;
    ClosestHit        rec;
    logic [$bits(ClosestHit)-1:0] fifo_dout;

    always_comb begin
        cur  = best_q[in_result.tag];
        // Strict less-than: on a tie the earlier box stays.
        take = in_result.ray_hit &&
               (!cur.hit || ($signed(in_result.tmin) < $signed(cur.tmin)));
        nb   = take ? '{hit: 1'b1, tmin: in_result.tmin, box: in_result.box} : cur;
        done = in_valid && !clear && (count_q[in_result.tag] == LAST);
        rec  = '{tag: in_result.tag, hit: nb.hit, tmin: nb.tmin, box: nb.box};

        best_d  = best_q;
        count_d = count_q;
        if (clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                best_d[i]  = ENTRY_CLEAR;
                count_d[i] = '0;
            end
        end else if (in_valid) begin
            if (done) begin
                best_d[in_result.tag]  = ENTRY_CLEAR;
                count_d[in_result.tag] = '0;
            end else begin
                best_d[in_result.tag]  = nb;
                count_d[in_result.tag] = count_q[in_result.tag] + 1'b1;
            end
        end

        busy_d = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            busy_d = busy_d | (count_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                best_q[i]  <= ENTRY_CLEAR;
                count_q[i] <= '0;
            end
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            best_q  <= best_d;
            count_q <= count_d;
            busy    <= busy_d;
            // A full FIFO is never empty, so out_ready alone means a pop frees a slot.
            if (done && fifo_full && !out_ready) overflow <= 1'b1;
        end
    end

    closest_hit_fifo #(
        .WIDTH ($bits(ClosestHit)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (done),
        .pop      (out_ready),
        .data_in  (rec),
        .data_out (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_hit   = ClosestHit'(fifo_dout);

endmodule

// File: tb/tb_aabb_closest_hit.sv
// tb/tb_aabb_closest_hit.sv - directed self-checking bench for aabb_closest_hit
module tb_aabb_closest_hit;
    import aabb_closest_hit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    AABB_result in_result;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    ClosestHit  out_hit;
    logic       overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    aabb_closest_hit #(.BOX_COUNT(4), .OUT_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_result (in_result),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hit   (out_hit),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic AABB mkbox(input int id);
        AABB b;
        b.x_min = 8'(id);
        b.y_min = 8'(id + 1);
        b.z_min = 8'(id + 2);
        b.x_max = 8'(id + 10);
        b.y_max = 8'(id + 11);
        b.z_max = 8'(id + 12);
        return b;
    endfunction

    function automatic ClosestHit mkrec(input int tag, input logic hit,
                                        input logic signed [WIDTH-1:0] tmin, input AABB box);
        ClosestHit r;
        r.tag  = TAG_SIZE'(tag);
        r.hit  = hit;
        r.tmin = tmin;
        r.box  = box;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int tag, input logic hit, input logic signed [WIDTH-1:0] tmin,
                        input AABB box);
        in_valid          = 1'b1;
        in_result.tag     = TAG_SIZE'(tag);
        in_result.ray_hit = hit;
        in_result.tmin    = tmin;
        in_result.box     = box;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Four beats: one hit at tmin on box id, three misses.
    task automatic rec4(input int tag, input logic signed [WIDTH-1:0] tmin, input int id);
        beat(tag, 1'b1, tmin, mkbox(id));
        beat(tag, 1'b0, MAX_16, mkbox(id + 50));
        beat(tag, 1'b0, MAX_16, mkbox(id + 60));
        beat(tag, 1'b0, MAX_16, mkbox(id + 70));
    endtask

    initial begin
        int pops;
        ClosestHit last_rec;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_hit",   out_hit,   '0);
        chk("reset_overflow",  overflow,  1'b0);
        chk("reset_busy",      busy,      1'b0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Tie on 2.0 keeps the earlier box.
        beat(3, 1'b1, 32'sh0005_0000, mkbox(1));
        beat(3, 1'b0, MAX_16,         mkbox(9));
        beat(3, 1'b1, 32'sh0002_0000, mkbox(2));
        chk("t1_busy_mid",      busy,      1'b1);
        chk("t1_no_early_out",  out_valid, 1'b0);
        beat(3, 1'b1, 32'sh0002_0000, mkbox(3));
        chk("t1_out_valid",     out_valid, 1'b1);
        chk("t1_record",        out_hit,   mkrec(3, 1'b1, 32'sh0002_0000, mkbox(2)));
        chk("t1_busy_done",     busy,      1'b0);
        @(posedge clk); #1;
        chk("t1_hold",          out_hit,   mkrec(3, 1'b1, 32'sh0002_0000, mkbox(2)));
        pop_one();
        chk("t1_popped",        out_valid, 1'b0);

        beat(5, 1'b0, 32'sh0001_0000, mkbox(30));
        chk("t2_busy_start",    busy,      1'b1);
        beat(5, 1'b0, 32'sh0001_0000, mkbox(31));
        beat(5, 1'b0, 32'sh0001_0000, mkbox(32));
        beat(5, 1'b0, 32'sh0001_0000, mkbox(33));
        chk("t2_record",        out_hit,   mkrec(5, 1'b0, 32'sh7fff_ffff, '0));
        chk("t2_busy",          busy,      1'b0);
        pop_one();

        // Tag 1 minimum 4.0 (box 11); tag 2 minimum -1.0 (box 22).
        beat(1, 1'b1, 32'sh0009_0000, mkbox(10));
        beat(2, 1'b1, 32'sh0003_0000, mkbox(20));
        beat(1, 1'b1, 32'sh0004_0000, mkbox(11));
        beat(2, 1'b1, 32'sh0008_0000, mkbox(21));
        beat(1, 1'b1, 32'sh0006_0000, mkbox(12));
        beat(2, 1'b1, 32'shffff_0000, mkbox(22));
        beat(1, 1'b0, 32'sh0001_0000, mkbox(13));
        chk("t3_first_out",     out_hit,   mkrec(1, 1'b1, 32'sh0004_0000, mkbox(11)));
        beat(2, 1'b1, 32'sh0005_0000, mkbox(23));
        chk("t3_head_stable",   out_hit,   mkrec(1, 1'b1, 32'sh0004_0000, mkbox(11)));
        pop_one();
        chk("t3_second_out",    out_hit,   mkrec(2, 1'b1, 32'shffff_0000, mkbox(22)));
        pop_one();
        chk("t3_empty",         out_valid, 1'b0);

        for (int k = 0; k < 17; k++) begin
            rec4(k % 8, fx(k + 1), k);
            if (k == 15) chk("t4_no_overflow_at_16", overflow, 1'b0);
        end
        chk("t4_overflow_set", overflow, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t4_order_%0d", k), out_hit, mkrec(k % 8, 1'b1, fx(k + 1), mkbox(k)));
            pop_one();
        end
        chk("t4_drained",       out_valid, 1'b0);
        chk("t4_overflow_sticky", overflow, 1'b1);

        beat(7, 1'b1, 32'sh0001_0000, mkbox(40));
        beat(7, 1'b1, 32'sh0001_0000, mkbox(41));
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("t5_reset_busy",    busy,      1'b0);
        chk("t5_reset_ovf",     overflow,  1'b0);
        for (int i = 0; i < 4; i++) beat(7, 1'b1, 32'sh0003_0000, mkbox(42 + i));
        chk("t5_record",        out_hit,   mkrec(7, 1'b1, 32'sh0003_0000, mkbox(42)));
        pop_one();
        chk("t5_single",        out_valid, 1'b0);

        beat(7, 1'b1, 32'sh0001_0000, mkbox(40));
        beat(7, 1'b1, 32'sh0001_0000, mkbox(41));
        clear = 1'b1;
        beat(7, 1'b1, 32'sh0000_8000, mkbox(99));
        clear = 1'b0;
        chk("t5c_clear_busy",   busy,      1'b0);
        chk("t5c_no_push",      out_valid, 1'b0);
        for (int i = 0; i < 4; i++) beat(7, 1'b1, 32'sh0003_0000, mkbox(42 + i));
        chk("t5c_record",       out_hit,   mkrec(7, 1'b1, 32'sh0003_0000, mkbox(42)));
        pop_one();
        chk("t5c_single",       out_valid, 1'b0);

        for (int k = 0; k < 16; k++) rec4(k % 8, fx(k + 1), k);
        chk("t6_full_no_ovf",   overflow,  1'b0);
        beat(0, 1'b1, 32'sh0064_0000, mkbox(77));
        beat(0, 1'b0, MAX_16, mkbox(78));
        beat(0, 1'b0, MAX_16, mkbox(79));
        out_ready = 1'b1;
        beat(0, 1'b0, MAX_16, mkbox(80));
        out_ready = 1'b0;
        chk("t6_overflow_clear", overflow, 1'b0);
        chk("t6_head_advanced", out_hit,   mkrec(1, 1'b1, fx(2), mkbox(1)));
        pops = 0;
        last_rec = '0;
        while (out_valid && pops < 40) begin
            last_rec = out_hit;
            pop_one();
            pops++;
        end
        chk("t6_occupancy",     pops,      16);
        chk("t6_last_record",   last_rec,  mkrec(0, 1'b1, 32'sh0064_0000, mkbox(77)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
